serial_operand_feeder: RTL and testbench
========================================

Name: serial_operand_feeder

Overview:
Upstream feeder for the bit-serial multiplier chain. It accepts a pair of parallel operands over a valid/ready handshake and shifts them out LSB-first as a qualified serial bit stream, one bit per accepted beat. The serial a/b bits, with their valid strobe, drive the first 2-bit block of the chain. Each operand stream is padded with FLUSH trailing beats so that the full 2*WIDTH-bit product drains out of the downstream blocks.

Parameters:
WIDTH, 8, operand width in bits (>=2)
FLUSH, WIDTH, number of pad beats appended after the WIDTH data beats (>=1)
SIGNED, 0, 0: pad beats carry 0; 1: pad beats repeat each operand's MSB (sign extension)

Ports:
i_clk  input  1  clock, rising edge
i_arstn  input  1  reset, asynchronous, active-low
i_in_valid  input  1  parallel operand pair valid
o_in_ready  output  1  feeder can accept an operand pair
i_a  input  WIDTH  operand A, parallel
i_b  input  WIDTH  operand B, parallel
i_out_ready  input  1  downstream accepts the current serial beat
o_valid  output  1  serial beat valid; drives the downstream valid/enable
o_a  output  1  serial bit of A
o_b  output  1  serial bit of B
o_first  output  1  current beat is beat 0 of a stream
o_last  output  1  current beat is beat WIDTH+FLUSH-1
o_busy  output  1  stream in progress (state != IDLE)

Behaviour:
- Reset is asynchronous and active-low, on i_arstn, with clock i_clk.
  - Values during reset: state=IDLE, shift registers=0, counter=0, pad bits=0.
  - Outputs during reset: o_valid=0, o_a=0, o_b=0, o_first=0, o_last=0, o_busy=0, o_in_ready=0.
  - o_in_ready rises on the first clock edge after reset release.
- Stream length L = WIDTH+FLUSH. Beat counter width is clog2(L).
- State IDLE: o_in_ready=1, o_valid=0.
  - On an accept edge (i_in_valid & o_in_ready), load a_sr<=i_a and b_sr<=i_b.
  - Latch pad_a/pad_b: MSB of the operand if SIGNED=1, else 0.
  - Set cnt<=0 and go to DATA.
- State DATA: o_valid=1, o_a=a_sr[0], o_b=b_sr[0], o_first=(cnt==0).
  - On a beat edge (o_valid & i_out_ready), shift right and fill with the pad bit; cnt<=cnt+1.
  - When cnt==WIDTH-1 on a beat edge, go to PAD.
- State PAD: o_valid=1, o_a=pad_a, o_b=pad_b, o_last=(cnt==L-1).
  - On a beat edge with o_last=1:
    - If i_in_valid=1: the new pair is accepted on the same edge; go to DATA with cnt=0 (back-to-back streams, no bubble).
    - Otherwise go to IDLE.
- o_in_ready = (state==IDLE) | (o_last & i_out_ready). It is combinational on i_out_ready only in the last beat.
- Stall: while i_out_ready=0, o_valid stays 1 and o_a, o_b, o_first, o_last, cnt and the shift registers hold their values.
- o_a, o_b, o_first and o_last are 0 whenever o_valid=0.
- Latency: for an accept on edge n, beat 0 is valid in the cycle after edge n. With no stalls the stream occupies exactly L cycles.
- i_a and i_b are sampled only on the accept edge. Changes at any other time are ignored.
- Reset asserted mid-stream: immediate return to the reset values. No partial stream resumes after reset.
- o_busy=1 in DATA and PAD.

Test Plan:
- Basic unsigned stream: WIDTH=8, FLUSH=8, SIGNED=0, i_a=8'hA5, i_b=8'h3C, i_out_ready=1.
  - o_a over 16 beats = 1,0,1,0,0,1,0,1 then eight 0s; o_b = 0,0,1,1,1,1,0,0 then eight 0s.
  - o_first on beat 0 only, o_last on beat 15 only, o_valid high for exactly 16 cycles.
- Signed padding: SIGNED=1, i_a=8'h80, i_b=8'h7F.
  - Pad beats 8-15: o_a=1, o_b=0.
  - Beats 0-7: o_a=0000_0001 (LSB first), o_b=1111_1110 (LSB first).
- Back-to-back: i_in_valid held high with two pairs (8'h01/8'h01 then 8'hFF/8'h02).
  - o_in_ready=1 during the beat-15 cycle; the second stream's o_first appears in the next cycle.
  - o_valid never drops; total of 32 valid beats.
- Stall: deassert i_out_ready for 3 cycles at beat 4 (i_a=8'hA5) and again at the last beat.
  - o_a=0 and cnt hold for 3 cycles; o_last held high.
  - o_in_ready stays 0 in the last beat until i_out_ready returns.
- Reset mid-stream: pull i_arstn low at beat 6.
  - All outputs go to 0 asynchronously, without waiting for a clock edge.
  - After release, o_in_ready=1 next edge and a fresh 8'h0F/8'h0F stream is emitted from beat 0.
- Idle input changes: change i_a and i_b every cycle during DATA and PAD with i_in_valid=0.
  - The serial stream is unaffected; the feeder goes to IDLE after beat L-1.

Source files
------------

// File: rtl/serial_operand_feeder_if.sv
// Handshake bundle between a parallel operand source and the serial feeder.
// The slave side is the feeder; the master side is whoever drives it.
interface serial_operand_feeder_if #(
   parameter int WIDTH = 8
);
   logic             i_in_valid;
   logic             o_in_ready;
   logic [WIDTH-1:0] i_a;
   logic [WIDTH-1:0] i_b;
   logic             i_out_ready;
   logic             o_valid;
   logic             o_a;
   logic             o_b;
   logic             o_first;
   logic             o_last;
   logic             o_busy;

   modport slave (
      input  i_in_valid, i_a, i_b, i_out_ready,
      output o_in_ready, o_valid, o_a, o_b, o_first, o_last, o_busy
   );

   modport master (
      output i_in_valid, i_a, i_b, i_out_ready,
      input  o_in_ready, o_valid, o_a, o_b, o_first, o_last, o_busy
   );
endinterface

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder for the bit-serial multiplier chain.
// Emits WIDTH data beats (LSB first) followed by FLUSH pad beats per pair,
// with back-to-back streams accepted on the final beat so no bubble appears.
module serial_operand_feeder #(
   parameter int WIDTH  = 8,
   parameter int FLUSH  = WIDTH,
   parameter bit SIGNED = 1'b0
) (
   input  logic                    i_clk,
   input  logic                    i_arstn,
   serial_operand_feeder_if.slave  bus
);
   localparam int L  = WIDTH + FLUSH;
   localparam int CW = $clog2(L);
   localparam logic [CW-1:0] CNT_DATA_END = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_LAST     = CW'(L - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_PAD  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             pad_a_q, pad_a_d;
   logic             pad_b_q, pad_b_d;
   // Held low through reset so o_in_ready only rises on the first edge after release.
   logic             rdy_q;

   logic valid_c, a_c, b_c, first_c, last_c, in_ready_c;
   logic accept_c, beat_c;

   // State and datapath registers; asynchronous active-low reset.
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         state_q <= S_IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         cnt_q   <= '0;
         pad_a_q <= 1'b0;
         pad_b_q <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         cnt_q   <= cnt_d;
         pad_a_q <= pad_a_d;
         pad_b_q <= pad_b_d;
         rdy_q   <= 1'b1;
      end
   end

   // Next-state logic and beat outputs; everything holds unless a beat or accept fires.
   always_comb begin
      state_d    = state_q;
      a_sr_d     = a_sr_q;
      b_sr_d     = b_sr_q;
      cnt_d      = cnt_q;
      pad_a_d    = pad_a_q;
      pad_b_d    = pad_b_q;
      valid_c    = 1'b0;
      a_c        = 1'b0;
      b_c        = 1'b0;
      first_c    = 1'b0;
      last_c     = 1'b0;
      in_ready_c = 1'b0;

      case (state_q)
         S_DATA: begin
            valid_c = 1'b1;
            a_c     = a_sr_q[0];
            b_c     = b_sr_q[0];
            first_c = (cnt_q == '0);
         end
         S_PAD: begin
            valid_c = 1'b1;
            a_c     = pad_a_q;
            b_c     = pad_b_q;
            last_c  = (cnt_q == CNT_LAST);
            // Ready is combinational on downstream ready only in the final beat.
            in_ready_c = last_c & bus.i_out_ready;
         end
         default: begin
            in_ready_c = rdy_q;
         end
      endcase

      accept_c = bus.i_in_valid & in_ready_c;
      beat_c   = valid_c & bus.i_out_ready;

      case (state_q)
         S_DATA: begin
            if (beat_c) begin
               a_sr_d = {pad_a_q, a_sr_q[WIDTH-1:1]};
               b_sr_d = {pad_b_q, b_sr_q[WIDTH-1:1]};
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_DATA_END) begin
                  state_d = S_PAD;
               end
            end
         end
         S_PAD: begin
            if (beat_c) begin
               if (last_c) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
         end
      endcase

      // Accept may come from IDLE or from the final pad beat (back-to-back).
      if (accept_c) begin
         a_sr_d  = bus.i_a;
         b_sr_d  = bus.i_b;
         pad_a_d = SIGNED ? bus.i_a[WIDTH-1] : 1'b0;
         pad_b_d = SIGNED ? bus.i_b[WIDTH-1] : 1'b0;
         cnt_d   = '0;
         state_d = S_DATA;
      end
   end

   assign bus.o_valid    = valid_c;
   assign bus.o_a        = a_c;
   assign bus.o_b        = b_c;
   assign bus.o_first    = first_c;
   assign bus.o_last     = last_c;
   assign bus.o_in_ready = in_ready_c;
   assign bus.o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Scoreboard bench: an unsigned and a signed feeder share one stimulus stream;
// expected beats are queued on accept and a negedge monitor compares each beat.
module tb_serial_operand_feeder;
   localparam int W  = 8;
   localparam int FL = 8;
   localparam int L  = W + FL;

   typedef struct packed {
      logic a;
      logic b;
      logic first;
      logic last;
   } exp_t;

   logic clk = 1'b0;
   logic arstn;
   logic in_valid, out_ready, rand_ready;
   logic [W-1:0] a_drv, b_drv;

   logic v[2], oa[2], ob[2], of[2], ol[2], rdy[2], busy[2];

   exp_t expq[2][$];
   int   checks = 0;
   int   errors = 0;
   int   cur_beat = 0;
   bit   warm = 1'b0;

   always #5 clk = ~clk;

   serial_operand_feeder_if #(.WIDTH(W)) if_u ();
   serial_operand_feeder_if #(.WIDTH(W)) if_s ();

   serial_operand_feeder #(.WIDTH(W), .FLUSH(FL), .SIGNED(1'b0)) dut_u (
      .i_clk(clk), .i_arstn(arstn), .bus(if_u.slave));
   serial_operand_feeder #(.WIDTH(W), .FLUSH(FL), .SIGNED(1'b1)) dut_s (
      .i_clk(clk), .i_arstn(arstn), .bus(if_s.slave));

   assign if_u.i_in_valid = in_valid;   assign if_s.i_in_valid = in_valid;
   assign if_u.i_a = a_drv;             assign if_s.i_a = a_drv;
   assign if_u.i_b = b_drv;             assign if_s.i_b = b_drv;
   assign if_u.i_out_ready = out_ready; assign if_s.i_out_ready = out_ready;

   assign v[0] = if_u.o_valid;    assign v[1] = if_s.o_valid;
   assign oa[0] = if_u.o_a;       assign oa[1] = if_s.o_a;
   assign ob[0] = if_u.o_b;       assign ob[1] = if_s.o_b;
   assign of[0] = if_u.o_first;   assign of[1] = if_s.o_first;
   assign ol[0] = if_u.o_last;    assign ol[1] = if_s.o_last;
   assign rdy[0] = if_u.o_in_ready; assign rdy[1] = if_s.o_in_ready;
   assign busy[0] = if_u.o_busy;  assign busy[1] = if_s.o_busy;

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, d, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s timed out at %0t", name, $time);
   endtask

   // Reference: beat k carries operand bit k, then pad (0 or the sign bit).
   task automatic push_model(input logic [W-1:0] pa, input logic [W-1:0] pb);
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < L; k++) begin
            exp_t e;
            if (k < W) begin
               e.a = pa[k];
               e.b = pb[k];
            end else begin
               e.a = (d == 1) ? pa[W-1] : 1'b0;
               e.b = (d == 1) ? pb[W-1] : 1'b0;
            end
            e.first = (k == 0);
            e.last  = (k == L - 1);
            expq[d].push_back(e);
         end
      end
   endtask

   // Present a pair until accepted, then queue its expected stream.
   task automatic send_pair(input logic [W-1:0] pa, input logic [W-1:0] pb);
      bit ok = 1'b0;
      in_valid = 1'b1;
      a_drv = pa;
      b_drv = pb;
      for (int n = 0; n < 400 && !ok; n++) begin
         @(negedge clk);
         if (rdy[0]) ok = 1'b1;
      end
      if (!ok) begin
         fail_now("accept");
      end else begin
         push_model(pa, pb);
         $display("accept a=%02h b=%02h at %0t", pa, pb, $time);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic count_run(input int req);
      int  n = 0;
      bit  seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (v[0]) seen = 1'b1;
      end
      if (!seen) begin
         fail_now("run_start");
      end else begin
         while (v[0] && n < 200) begin
            n++;
            @(negedge clk);
         end
         chk("run_len", 0, 32'(n), 32'(req));
      end
   endtask

   task automatic wait_beat(input int k);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (v[0] && cur_beat == k) ok = 1'b1;
      end
      if (!ok) fail_now("wait_beat");
   endtask

   task automatic stall3();
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
   endtask

   task automatic drain();
      bit ok = 1'b0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (expq[0].size() == 0 && expq[1].size() == 0 && !v[0] && !v[1]) ok = 1'b1;
      end
      if (!ok) fail_now("drain");
   endtask

   task automatic chk_all_zero(input string name);
      for (int d = 0; d < 2; d++)
         chk(name, d, 32'({v[d], oa[d], ob[d], of[d], ol[d], busy[d], rdy[d]}), 32'd0);
   endtask

   always @(posedge clk or negedge arstn) begin
      if (!arstn) warm = 1'b0;
      else        warm = 1'b1;
   end

   // Downstream ready: random back-pressure when enabled.
   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 99) >= 30);
   end

   // Operand inputs wander whenever no pair is being offered.
   always @(negedge clk) begin
      #1;
      if (!in_valid) begin
         a_drv = W'($urandom);
         b_drv = W'($urandom);
      end
   end

   // Monitor: every presented beat must equal the head of the scoreboard.
   always @(negedge clk) begin
      if (arstn) begin
         for (int d = 0; d < 2; d++) begin
            chk("busy_vs_valid", d, 32'(busy[d]), 32'(v[d]));
            if (!v[d]) begin
               chk("idle_outputs", d, 32'({oa[d], ob[d], of[d], ol[d]}), 32'd0);
               if (warm) chk("idle_ready", d, 32'(rdy[d]), 32'd1);
            end else if (expq[d].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat dut%0d actual=valid required=idle at %0t", d, $time);
            end else begin
               exp_t e;
               e = expq[d][0];
               chk("beat", d, 32'({oa[d], ob[d], of[d], ol[d]}), 32'(e));
               chk("in_ready", d, 32'(rdy[d]), 32'(e.last & out_ready));
               if (out_ready) begin
                  void'(expq[d].pop_front());
                  if (d == 0) cur_beat = e.last ? 0 : cur_beat + 1;
               end
            end
         end
      end
   end

   initial begin
      arstn = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      rand_ready = 1'b0;
      a_drv = '0;
      b_drv = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset_outputs");
      #2;
      arstn = 1'b1;
      chk("ready_before_edge", 0, 32'(rdy[0]), 32'd0);
      @(posedge clk);
      #1;
      chk("ready_after_edge", 0, 32'(rdy[0]), 32'd1);

      // Basic unsigned pattern; stream is exactly L valid cycles.
      fork
         send_pair(8'hA5, 8'h3C);
         count_run(L);
      join
      drain();

      // Sign-extension pattern.
      send_pair(8'h80, 8'h7F);
      drain();

      // Back-to-back: valid never drops across two streams.
      fork
         begin
            send_pair(8'h01, 8'h01);
            send_pair(8'hFF, 8'h02);
         end
         count_run(2 * L);
      join
      drain();

      // Stall at beat 4 and again in the last beat.
      send_pair(8'hA5, 8'h3C);
      wait_beat(4);
      stall3();
      wait_beat(L - 1);
      stall3();
      drain();

      // Asynchronous reset in the middle of a stream.
      send_pair(8'h5A, 8'hC3);
      wait_beat(6);
      #2;
      arstn = 1'b0;
      #1;
      chk_all_zero("async_reset");
      for (int d = 0; d < 2; d++) expq[d].delete();
      cur_beat = 0;
      repeat (2) @(posedge clk);
      #2;
      arstn = 1'b1;
      chk("ready_before_edge2", 0, 32'(rdy[0]), 32'd0);
      @(posedge clk);
      #1;
      chk("ready_after_edge2", 0, 32'(rdy[0]), 32'd1);
      send_pair(8'h0F, 8'h0F);
      drain();

      // Random pairs, random gaps, random back-pressure.
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send_pair(W'($urandom), W'($urandom));
      end
      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      drain();

      for (int d = 0; d < 2; d++) chk("queue_empty", d, 32'(expq[d].size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
